// File: rtl/mips32_pipe_core.sv
// mips32_pipe_core: five-stage (IF/ID/EX/MEM/WB) pipelined 32-bit core with a
// small MIPS-like ISA, a private 32x32 register file and a unified
// word-addressed instruction/data memory. Runs from RESET_PC until HLT retires.
module mips32_pipe_core #(
  parameter int MEM_DEPTH = 1024,
  parameter int RESET_PC  = 0
) (
  input  logic clk,
  input  logic rst,
  output logic halted
);

  localparam int AW = $clog2(MEM_DEPTH);

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  // Instruction class; K_NOP doubles as the bubble encoding (all-zero latch).
  typedef enum logic [2:0] {
    K_NOP, K_RR, K_RM, K_LW, K_SW, K_BR, K_HLT
  } kind_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] ir;
    logic [31:0] npc;
  } if_id_t;

  typedef struct packed {
    kind_e       kind;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic        wr;    // writes a nonzero register
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] npc;
  } id_ex_t;

  typedef struct packed {
    kind_e       kind;
    logic [4:0]  dest;
    logic        wr;
    logic [31:0] alu;
    logic [31:0] b;
  } ex_mem_t;

  typedef struct packed {
    kind_e       kind;
    logic [4:0]  dest;
    logic        wr;
    logic [31:0] result;
  } mem_wb_t;

  // Architectural state; names are fixed so the bench can preload and inspect.
  logic [31:0] Reg [0:31];
  logic [31:0] Mem [0:MEM_DEPTH-1];
  logic [31:0] PC;
  logic        HALTED;
  logic        TAKEN_BRANCH;

  if_id_t  if_id;
  id_ex_t  id_ex,  id_ex_d;
  ex_mem_t ex_mem, ex_mem_d;
  mem_wb_t mem_wb, mem_wb_d;

  logic [5:0]  id_op;
  logic [4:0]  id_rs, id_rt, id_rd;
  kind_e       id_kind;
  logic [31:0] fa, fb, alu, br_target;
  logic        hlt_stop;

  assign halted = HALTED;
  assign id_op  = if_id.ir[31:26];
  assign id_rs  = if_id.ir[25:21];
  assign id_rt  = if_id.ir[20:16];
  assign id_rd  = if_id.ir[15:11];

  // ID: classify the opcode; invalid slots and unknown opcodes become NOPs.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    id_kind = K_NOP;
    if (if_id.valid) begin
      case (id_op)
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: id_kind = K_RR;
        OP_ADDI, OP_SUBI, OP_SLTI:                     id_kind = K_RM;
        OP_LW:                                         id_kind = K_LW;
        OP_SW:                                         id_kind = K_SW;
        OP_BNEQZ, OP_BEQZ:                             id_kind = K_BR;
        OP_HLT:                                        id_kind = K_HLT;
        default:                                       id_kind = K_NOP;
      endcase
    end
  end

  // ID: build the ID/EX payload; register reads see a same-cycle WB write.
  always_comb begin
    id_ex_d      = '0;
    id_ex_d.kind = id_kind;
    id_ex_d.op   = id_op;
    id_ex_d.rs   = id_rs;
    id_ex_d.rt   = id_rt;
    id_ex_d.imm  = {{16{if_id.ir[15]}}, if_id.ir[15:0]};
    id_ex_d.npc  = if_id.npc;
    id_ex_d.dest = (id_kind == K_RR) ? id_rd : id_rt;
    id_ex_d.wr   = (id_kind == K_RR || id_kind == K_RM || id_kind == K_LW) &&
                   (id_ex_d.dest != 5'd0);
    if (id_rs == 5'd0)                         id_ex_d.a = '0;
    else if (mem_wb.wr && mem_wb.dest == id_rs) id_ex_d.a = mem_wb.result;
    else                                       id_ex_d.a = Reg[id_rs];
    if (id_rt == 5'd0)                         id_ex_d.b = '0;
    else if (mem_wb.wr && mem_wb.dest == id_rt) id_ex_d.b = mem_wb.result;
    else                                       id_ex_d.b = Reg[id_rt];
  end

  // EX: operand forwarding (EX/MEM ALU results first, then MEM/WB), ALU, branch.
  always_comb begin
    fa = id_ex.a;
    if (ex_mem.wr && ex_mem.kind != K_LW && ex_mem.dest == id_ex.rs) fa = ex_mem.alu;
    else if (mem_wb.wr && mem_wb.dest == id_ex.rs)                  fa = mem_wb.result;
    fb = id_ex.b;
    if (ex_mem.wr && ex_mem.kind != K_LW && ex_mem.dest == id_ex.rt) fb = ex_mem.alu;
    else if (mem_wb.wr && mem_wb.dest == id_ex.rt)                  fb = mem_wb.result;

    alu = '0;
    case (id_ex.kind)
      K_RR: begin
        case (id_ex.op)
          OP_ADD:  alu = fa + fb;
          OP_SUB:  alu = fa - fb;
          OP_AND:  alu = fa & fb;
          OP_OR:   alu = fa | fb;
          OP_SLT:  alu = {31'd0, $signed(fa) < $signed(fb)};
          OP_MUL:  alu = fa * fb;
          default: alu = '0;
        endcase
      end
      K_RM: begin
        case (id_ex.op)
          OP_ADDI: alu = fa + id_ex.imm;
          OP_SUBI: alu = fa - id_ex.imm;
          OP_SLTI: alu = {31'd0, $signed(fa) < $signed(id_ex.imm)};
          default: alu = '0;
        endcase
      end
      K_LW, K_SW: alu = fa + id_ex.imm;
      default:    alu = '0;
    endcase

    br_target    = id_ex.npc + id_ex.imm;
    TAKEN_BRANCH = !HALTED && id_ex.kind == K_BR &&
                   ((id_ex.op == OP_BNEQZ && fa != 32'd0) ||
                    (id_ex.op == OP_BEQZ  && fa == 32'd0));

    ex_mem_d      = '0;
    ex_mem_d.kind = id_ex.kind;
    ex_mem_d.dest = id_ex.dest;
    ex_mem_d.wr   = id_ex.wr;
    ex_mem_d.alu  = alu;
    ex_mem_d.b    = fb;
  end

  // MEM: loads read memory here; everything else passes the ALU result on.
  always_comb begin
    mem_wb_d        = '0;
    mem_wb_d.kind   = ex_mem.kind;
    mem_wb_d.dest   = ex_mem.dest;
    mem_wb_d.wr     = ex_mem.wr;
    mem_wb_d.result = (ex_mem.kind == K_LW) ? Mem[ex_mem.alu[AW-1:0]] : ex_mem.alu;
  end

  // Fetch stops while an unsquashed HLT is anywhere from ID to WB.
  always_comb begin
    hlt_stop = (id_kind == K_HLT && !TAKEN_BRANCH) ||
               id_ex.kind == K_HLT || ex_mem.kind == K_HLT || mem_wb.kind == K_HLT;
  end

  // Pipeline latches, PC and HALTED; everything freezes once HALTED is set.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      PC     <= 32'(RESET_PC);
      HALTED <= 1'b0;
      if_id  <= '0;
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
    end else if (!HALTED) begin
      ex_mem <= ex_mem_d;
      mem_wb <= mem_wb_d;
      if (TAKEN_BRANCH) begin
        PC    <= br_target;
        if_id <= '0;
        id_ex <= '0;
      end else begin
        id_ex <= id_ex_d;
        if (hlt_stop) begin
          if_id <= '0;
        end else begin
          if_id <= '{valid: 1'b1, ir: Mem[PC[AW-1:0]], npc: PC + 32'd1};
          PC    <= PC + 32'd1;
        end
      end
      if (mem_wb.kind == K_HLT) HALTED <= 1'b1;
    end
  end

  // Register-file writeback (WB) and store (MEM).
  always_ff @(posedge clk) begin
    // NOTE: storage arrays carry no reset; software is preloaded and must
    // survive rst, and resetting a RAM would prevent RAM inference.
    if (!rst && !HALTED) begin
      if (mem_wb.wr)           Reg[mem_wb.dest] <= mem_wb.result;
      if (ex_mem.kind == K_SW) Mem[ex_mem.alu[AW-1:0]] <= ex_mem.b;
    end
  end

endmodule

// File: tb/tb_mips32_pipe_core.sv
// Directed bench for mips32_pipe_core: small programs preloaded into Mem,
// results compared against hand-computed register/memory values and timing.
module tb_mips32_pipe_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic halted;

  int total = 0;
  int bad   = 0;

  logic [31:0] r2_trace[$];
  logic [31:0] last_r2;
  int          mem198_bad;
  int          cyc;

  mips32_pipe_core #(.MEM_DEPTH(1024), .RESET_PC(0)) dut (
    .clk    (clk),
    .rst    (rst),
    .halted (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
    end
  endtask

  // Assert rst across two edges; caller then loads state before release.
  task automatic enter_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_state();
    for (int i = 0; i < 1024; i++) dut.Mem[i] = 32'd0;
    for (int k = 0; k < 32; k++)   dut.Reg[k] = 32'(k);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rst_pc"},     dut.PC, 32'd0);
    check({tag, "_rst_halted"}, {31'd0, halted}, 32'd0);
    check({tag, "_rst_taken"},  {31'd0, dut.TAKEN_BRANCH}, 32'd0);
  endtask

  // Release reset (if held) and clock until halted or the cycle budget ends.
  task automatic run_to_halt(input string tag, input int limit, output int cycles);
    cycles     = 0;
    mem198_bad = 0;
    r2_trace.delete();
    last_r2 = dut.Reg[2];
    @(negedge clk);
    rst = 1'b0;
    while (cycles < limit && !halted) begin
      @(posedge clk);
      #1;
      cycles++;
      if (dut.Reg[2] !== last_r2) begin
        r2_trace.push_back(dut.Reg[2]);
        last_r2 = dut.Reg[2];
      end
      if (dut.Mem[198] !== 32'd0 && dut.Mem[198] !== 32'd5040) mem198_bad++;
    end
    check({tag, "_halted"}, {31'd0, halted}, 32'd1);
  endtask

  initial begin
    logic [31:0] fact_exp [7];
    fact_exp = '{32'd1, 32'd7, 32'd42, 32'd210, 32'd840, 32'd2520, 32'd5040};

    // ALU chain with dummy ORs; HLT at word 8 retires at edge 13.
    enter_reset();
    clear_state();
    dut.Mem[0] = 32'h2801000a; dut.Mem[1] = 32'h28020014; dut.Mem[2] = 32'h28030019;
    dut.Mem[3] = 32'h0ce77800; dut.Mem[4] = 32'h0ce77800; dut.Mem[5] = 32'h00222000;
    dut.Mem[6] = 32'h0ce77800; dut.Mem[7] = 32'h00832800; dut.Mem[8] = 32'hfc000000;
    check_reset_state("alu");
    run_to_halt("alu", 200, cyc);
    check("alu_cycles", 32'(cyc), 32'd13);
    check("alu_r1", dut.Reg[1], 32'd10);
    check("alu_r2", dut.Reg[2], 32'd20);
    check("alu_r3", dut.Reg[3], 32'd25);
    check("alu_r4", dut.Reg[4], 32'd30);
    check("alu_r5", dut.Reg[5], 32'd55);
    check("alu_r0", dut.Reg[0], 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("alu_frozen_pc", dut.PC, 32'd9);
    check("alu_frozen_halted", {31'd0, halted}, 32'd1);

    // Load/store with LW result consumed two instructions later.
    enter_reset();
    clear_state();
    dut.Mem[0] = 32'h28010078; dut.Mem[1] = 32'h0c631800; dut.Mem[2] = 32'h20220000;
    dut.Mem[3] = 32'h0c631800; dut.Mem[4] = 32'h2842002d; dut.Mem[5] = 32'h0c631800;
    dut.Mem[6] = 32'h24220001; dut.Mem[7] = 32'hfc000000;
    dut.Mem[120] = 32'd85;
    run_to_halt("ls", 200, cyc);
    check("ls_mem120", dut.Mem[120], 32'd85);
    check("ls_mem121", dut.Mem[121], 32'd130);
    check("ls_r2", dut.Reg[2], 32'd130);

    // Factorial loop: 7! stored at 198, SW only after the loop exits.
    enter_reset();
    clear_state();
    dut.Mem[0] = 32'h280a00c8; dut.Mem[1] = 32'h28020001; dut.Mem[2] = 32'h0e94a000;
    dut.Mem[3] = 32'h21430000; dut.Mem[4] = 32'h0e94a000; dut.Mem[5] = 32'h14431000;
    dut.Mem[6] = 32'h2c630001; dut.Mem[7] = 32'h0e94a000; dut.Mem[8] = 32'h3460fffc;
    dut.Mem[9] = 32'h2542fffe; dut.Mem[10] = 32'hfc000000;
    dut.Mem[200] = 32'd7;
    run_to_halt("fact", 1000, cyc);
    check("fact_mem198", dut.Mem[198], 32'd5040);
    check("fact_mem200", dut.Mem[200], 32'd7);
    check("fact_r3", dut.Reg[3], 32'd0);
    check("fact_early_sw", 32'(mem198_bad), 32'd0);
    check("fact_trace_len", 32'(r2_trace.size()), 32'd7);
    for (int i = 0; i < 7; i++)
      check($sformatf("fact_trace%0d", i),
            (i < r2_trace.size()) ? r2_trace[i] : 32'hdeadbeef, fact_exp[i]);

    // Forwarding: EX/MEM, MEM/WB and WB->ID paths, plus SUB/SLT signedness.
    enter_reset();
    clear_state();
    dut.Mem[0] = 32'h28010005; dut.Mem[1] = 32'h00211000; dut.Mem[2] = 32'h00411800;
    dut.Mem[3] = 32'h00222000; dut.Mem[4] = 32'h04012800; dut.Mem[5] = 32'h10a13000;
    dut.Mem[6] = 32'hfc000000;
    run_to_halt("fwd", 200, cyc);
    check("fwd_r1", dut.Reg[1], 32'd5);
    check("fwd_r2", dut.Reg[2], 32'd10);
    check("fwd_r3", dut.Reg[3], 32'd15);
    check("fwd_r4", dut.Reg[4], 32'd15);
    check("fwd_r5", dut.Reg[5], 32'hfffffffb);
    check("fwd_r6", dut.Reg[6], 32'd1);

    // Branch squash: BEQZ R0,+2 skips two ADDIs, resumes at word 3.
    enter_reset();
    clear_state();
    dut.Mem[0] = 32'h38000002; dut.Mem[1] = 32'h28050001; dut.Mem[2] = 32'h28060001;
    dut.Mem[3] = 32'h28070009; dut.Mem[4] = 32'hfc000000;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("br_taken_ex", {31'd0, dut.TAKEN_BRANCH}, 32'd1);
    @(posedge clk); #1;
    check("br_pc_target", dut.PC, 32'd3);
    check("br_taken_clear", {31'd0, dut.TAKEN_BRANCH}, 32'd0);
    run_to_halt("br", 200, cyc);
    check("br_r5", dut.Reg[5], 32'd5);
    check("br_r6", dut.Reg[6], 32'd6);
    check("br_r7", dut.Reg[7], 32'd9);

    // A HLT in the branch shadow is squashed and fetch resumes at the target.
    enter_reset();
    clear_state();
    dut.Mem[0] = 32'h38000001; dut.Mem[1] = 32'hfc000000; dut.Mem[2] = 32'h28070003;
    dut.Mem[3] = 32'hfc000000;
    run_to_halt("hsq", 200, cyc);
    check("hsq_r7", dut.Reg[7], 32'd3);
    check("hsq_pc", dut.PC, 32'd4);

    // Reset in the middle of the factorial loop, then full re-execution.
    enter_reset();
    clear_state();
    dut.Mem[0] = 32'h280a00c8; dut.Mem[1] = 32'h28020001; dut.Mem[2] = 32'h0e94a000;
    dut.Mem[3] = 32'h21430000; dut.Mem[4] = 32'h0e94a000; dut.Mem[5] = 32'h14431000;
    dut.Mem[6] = 32'h2c630001; dut.Mem[7] = 32'h0e94a000; dut.Mem[8] = 32'h3460fffc;
    dut.Mem[9] = 32'h2542fffe; dut.Mem[10] = 32'hfc000000;
    dut.Mem[200] = 32'd7;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("mid_running", {31'd0, halted}, 32'd0);
    enter_reset();
    dut.Mem[198] = 32'd0;
    dut.Reg[2]   = 32'd0;
    check_reset_state("mid");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_first_fetch_pc", dut.PC, 32'd1);
    run_to_halt("mid", 1000, cyc);
    check("mid_mem198", dut.Mem[198], 32'd5040);
    check("mid_r2", dut.Reg[2], 32'd5040);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
